uart8_rx_controller: RTL and testbench

//  Sequences and buffers the 8-bit UART receiver for a host interface, on the receiver's 16x oversample clock.

---
 rtl/uart_rx_ctrl_pkg.sv | 34 +++
 rtl/uart_byte_fifo.sv | 68 ++++++
 rtl/uart8_rx_controller.sv | 156 +++++++++++++++
 tb/tb_uart8_rx_controller.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// ============================================================================
// Module   : uart_rx_ctrl_pkg
// Brief    : Shared state encoding and sizing helper for the UART8 RX controller
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_rx_ctrl_pkg;

    localparam logic [1:0] C_ST_OFF   = 2'd0;
    localparam logic [1:0] C_ST_ON    = 2'd1;
    localparam logic [1:0] C_ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        ST_OFF   = C_ST_OFF,
        ST_ON    = C_ST_ON,
        ST_DRAIN = C_ST_DRAIN
    } rx_state_t;

    // Bits needed to index 'value' entries; a floor of 1 keeps vectors legal.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
// ============================================================================
// Module   : uart_byte_fifo
// Brief    : First-word-fall-through byte FIFO; head/valid derive from registers
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_byte_fifo
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       valid,
    output logic       full
);

    localparam int             C_AW   = clog2(DEPTH);
    localparam logic [C_AW:0]  C_FULL = DEPTH[C_AW:0];

    logic [7:0]      r_mem [DEPTH];
    logic [C_AW-1:0] r_wr_ptr;
    logic [C_AW-1:0] r_rd_ptr;
    logic [C_AW:0]   r_count;
    logic            w_wr_en;
    logic            w_rd_en;

    assign valid   = (r_count != '0);
    assign full    = (r_count == C_FULL);
    assign w_rd_en = pop && valid;
    // A full FIFO still accepts a byte when the head leaves on the same tick.
    assign w_wr_en = push && (!full || w_rd_en);
    assign head    = valid ? r_mem[r_rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart8_rx_controller.sv
// ============================================================================
// Module   : uart8_rx_controller
// Brief    : Enable sequencing, byte capture, buffering and status for UART RX
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart8_rx_controller
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int DRAIN_TICKS = 192,
    parameter int OFF_TICKS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_req,
    output logic       rx_en,
    input  logic       rx_busy,
    input  logic       rx_done,
    input  logic       rx_err,
    input  logic [7:0] rx_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow,
    output logic [7:0] err_count,
    input  logic       clr_status,
    output logic       active
);

    localparam int C_OFF_W        = clog2(OFF_TICKS + 1);
    localparam int C_DRAIN_W      = clog2(DRAIN_TICKS);
    localparam int C_DRAIN_LAST_I = DRAIN_TICKS - 1;
    localparam logic [C_OFF_W-1:0]   C_OFF_MAX    = OFF_TICKS[C_OFF_W-1:0];
    localparam logic [C_DRAIN_W-1:0] C_DRAIN_LAST = C_DRAIN_LAST_I[C_DRAIN_W-1:0];

    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic                 w_active;
    logic [C_OFF_W-1:0]   r_off_cnt;
    logic [C_DRAIN_W-1:0] r_drain_cnt;
    logic                 r_done_q;
    logic                 r_err_q;
    logic                 r_overflow;
    logic [7:0]           r_err_count;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_err_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_active    = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (enable_req && (r_off_cnt == C_OFF_MAX)) begin
                    w_state_nxt = ST_ON;
                end
            end
            ST_ON: begin
                w_active = 1'b1;
                if (!enable_req) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_active = 1'b1;
                // A renewed request wins over finishing the shutdown.
                if (enable_req) begin
                    w_state_nxt = ST_ON;
                end else if (!rx_busy || (r_drain_cnt == C_DRAIN_LAST)) begin
                    w_state_nxt = ST_OFF;
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
            end
        endcase
    end

    assign rx_en  = w_active;
    assign active = w_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_off_cnt   <= '0;
            r_drain_cnt <= '0;
        end else begin
            if ((w_state_nxt == ST_OFF) && (r_state != ST_OFF)) begin
                r_off_cnt <= '0;
            end else if ((r_state == ST_OFF) && (r_off_cnt != C_OFF_MAX)) begin
                r_off_cnt <= r_off_cnt + 1'b1;
            end
            if ((w_state_nxt == ST_DRAIN) && (r_state != ST_DRAIN)) begin
                r_drain_cnt <= '0;
            end else if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end
        end
    end

    assign w_push     = rx_done && !r_done_q && w_active;
    assign w_err_edge = rx_err && !r_err_q && w_active;
    assign w_pop      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_q    <= 1'b0;
            r_err_q     <= 1'b0;
            r_overflow  <= 1'b0;
            r_err_count <= 8'h00;
        end else begin
            r_done_q <= rx_done;
            r_err_q  <= rx_err;
            if (clr_status) begin
                r_overflow  <= 1'b0;
                r_err_count <= 8'h00;
            end else begin
                if (w_push && w_full && !w_pop) begin
                    r_overflow <= 1'b1;
                end
                if (w_err_edge && (r_err_count != 8'hFF)) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end
        end
    end

    assign overflow  = r_overflow;
    assign err_count = r_err_count;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (rx_data),
        .pop       (w_pop),
        .head      (out_data),
        .valid     (out_valid),
        .full      (w_full)
    );

endmodule

`default_nettype wire

// File: tb/tb_uart8_rx_controller.sv
// ============================================================================
// Module   : tb_uart8_rx_controller
// Brief    : Directed tables, corner sequences and random traffic vs a queue model
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart8_rx_controller;

    localparam int DEPTH       = 4;
    localparam int DRAIN_TICKS = 192;
    localparam int OFF_TICKS   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable_req = 1'b0;
    logic       rx_busy = 1'b0;
    logic       rx_done = 1'b0;
    logic       rx_err = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       clr_status = 1'b0;
    logic       rx_en;
    logic [7:0] out_data;
    logic       out_valid;
    logic       overflow;
    logic [7:0] err_count;
    logic       active;

    always #5 clk = ~clk;

    uart8_rx_controller #(
        .DEPTH       (DEPTH),
        .DRAIN_TICKS (DRAIN_TICKS),
        .OFF_TICKS   (OFF_TICKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable_req (enable_req),
        .rx_en      (rx_en),
        .rx_busy    (rx_busy),
        .rx_done    (rx_done),
        .rx_err     (rx_err),
        .rx_data    (rx_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .err_count  (err_count),
        .clr_status (clr_status),
        .active     (active)
    );

    int checks   = 0;
    int failures = 0;
    bit rand_mode = 1'b0;

    // Reference: mode 0=off 1=on 2=drain, bytes held in a queue.
    int          m_mode  = 0;
    int          m_off   = 0;
    int          m_drain = 0;
    byte unsigned m_q[$];
    bit          m_ovf   = 1'b0;
    int          m_err   = 0;
    bit          m_done_q = 1'b0;
    bit          m_err_q  = 1'b0;

    task automatic model_tick();
        bit act, pop, push, eedge;
        if (rst) begin
            m_mode = 0; m_off = 0; m_drain = 0; m_q.delete();
            m_ovf = 1'b0; m_err = 0; m_done_q = 1'b0; m_err_q = 1'b0;
            return;
        end
        act   = (m_mode != 0);
        pop   = (m_q.size() != 0) && out_ready;
        push  = rx_done && !m_done_q && act;
        eedge = rx_err && !m_err_q && act;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(rx_data);
            else m_ovf = 1'b1;
        end
        if (clr_status) begin
            m_ovf = 1'b0;
            m_err = 0;
        end else if (eedge && m_err < 255) begin
            m_err++;
        end
        case (m_mode)
            0: if (enable_req && m_off == OFF_TICKS) m_mode = 1;
               else if (m_off < OFF_TICKS) m_off++;
            1: if (!enable_req) begin m_mode = 2; m_drain = 0; end
            default: begin
                if (enable_req) m_mode = 1;
                else if (!rx_busy || m_drain == DRAIN_TICKS - 1) begin m_mode = 0; m_off = 0; end
                else m_drain++;
            end
        endcase
        m_done_q = rx_done;
        m_err_q  = rx_err;
    endtask

    task automatic model_compare();
        bit         e_en, e_valid;
        logic [7:0] e_data;
        e_en    = (m_mode != 0);
        e_valid = (m_q.size() != 0);
        e_data  = e_valid ? m_q[0] : 8'h00;
        checks++;
        if (rx_en !== e_en || active !== e_en || out_valid !== e_valid || out_data !== e_data ||
            overflow !== m_ovf || err_count !== 8'(m_err)) begin
            failures++;
            $display("FAIL model t=%0t got en=%b act=%b v=%b d=%h ovf=%b err=%0d exp en=%b v=%b d=%h ovf=%b err=%0d",
                     $time, rx_en, active, out_valid, out_data, overflow, err_count,
                     e_en, e_valid, e_data, m_ovf, m_err);
        end
    endtask

    // One clock: model consumes the inputs the DUT is about to sample.
    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        model_compare();
        if (rand_mode) begin
            out_ready  = ($urandom_range(0, 1) == 1);
            clr_status = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 299) == 0) enable_req = !enable_req;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Behavioural receiver: 9 bit-times busy, then 16 ticks of done (or error) at the stop bit.
    task automatic frame(input logic [7:0] d, input bit bad, input int drop_at, input bit pop_on_done);
        rx_busy = 1'b1;
        for (int t = 0; t < 144; t++) begin
            step();
            if (t == drop_at) enable_req = 1'b0;
            if (!rx_en) begin
                rx_busy = 1'b0;
                return;
            end
        end
        if (bad) rx_err = 1'b1;
        else begin
            rx_done = 1'b1;
            rx_data = d;
        end
        if (pop_on_done) out_ready = 1'b1;
        for (int t = 0; t < 16; t++) begin
            step();
            if (t == 0 && pop_on_done) out_ready = 1'b0;
            if (!rx_en) break;
        end
        rx_done = 1'b0;
        rx_err  = 1'b0;
        rx_busy = 1'b0;
        step();
    endtask

    task automatic wait_enabled(input string name);
        for (int i = 0; i < 10 && !rx_en; i++) step();
        check(name, rx_en, 1);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         bad;
        logic       exp_valid;
        logic [7:0] exp_head;
        logic [7:0] exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cnt;
        vecs[0] = '{8'hC3, 1'b0, 1'b1, 8'hC3, 8'd0};
        vecs[1] = '{8'h77, 1'b1, 1'b1, 8'hC3, 8'd1};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 8'hC3, 8'd1};
        vecs[3] = '{8'h12, 1'b1, 1'b1, 8'hC3, 8'd2};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hC3, 8'd3};

        rst = 1'b1; enable_req = 1'b1;
        repeat (3) step();
        check("rst_en", rx_en, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_status", {overflow, err_count, active}, 0);
        rst = 1'b0;
        step(); check("en_tick1", rx_en, 0);
        step(); check("en_tick2", rx_en, 0);
        step(); check("en_tick3", rx_en, 1);

        frame(8'hA5, 1'b0, -1, 1'b0);
        check("a5_valid", out_valid, 1);
        check("a5_data", out_data, 8'hA5);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("a5_popped", out_valid, 0);

        for (int i = 0; i < 5; i++) begin
            frame(vecs[i].data, vecs[i].bad, -1, 1'b0);
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_head", i), out_data, vecs[i].exp_head);
            check($sformatf("vec%0d_err", i), err_count, vecs[i].exp_err);
        end
        rx_err = 1'b1; clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("clr_vs_edge", err_count, 0);
        repeat (15) step();
        rx_err = 1'b0; step();
        check("clr_held_err", err_count, 0);
        out_ready = 1'b1;
        check("tbl_pop0", out_data, 8'hC3); step();
        check("tbl_pop1", out_data, 8'h3C); step();
        check("tbl_empty", out_valid, 0);
        out_ready = 1'b0;

        for (int i = 1; i <= 5; i++) frame(8'(i), 1'b0, -1, 1'b0);
        check("ovf_set", overflow, 1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_pop%0d", i), out_data, 8'(i));
            step();
        end
        out_ready = 1'b0;
        check("ovf_empty", out_valid, 0);
        check("ovf_sticky", overflow, 1);

        clr_status = 1'b1; step(); clr_status = 1'b0;
        check("ovf_clr", overflow, 0);
        for (int i = 1; i <= 4; i++) frame(8'(i), 1'b0, -1, 1'b0);
        frame(8'h05, 1'b0, -1, 1'b1);
        check("full_pop_no_ovf", overflow, 0);
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check($sformatf("full_pop%0d", i), out_data, 8'(i));
            step();
        end
        out_ready = 1'b0;
        check("full_empty", out_valid, 0);

        frame(8'h3C, 1'b0, 48, 1'b0);
        check("drain_off", rx_en, 0);
        check("drain_byte", out_data, 8'h3C);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        enable_req = 1'b1;
        wait_enabled("forced_en");
        rx_busy = 1'b1;
        repeat (16) step();
        enable_req = 1'b0;
        cnt = 0;
        while (rx_en && cnt < 400) begin
            step();
            cnt++;
        end
        rx_busy = 1'b0;
        check("forced_ticks", cnt, 1 + DRAIN_TICKS);
        check("forced_nopush", out_valid, 0);

        rx_done = 1'b1; rx_data = 8'h55;
        repeat (2) step();
        rx_done = 1'b0; step();
        check("off_done_ignored", out_valid, 0);

        enable_req = 1'b1;
        wait_enabled("rst_drain_en");
        frame(8'h00, 1'b1, -1, 1'b0);
        frame(8'h11, 1'b0, -1, 1'b0);
        frame(8'h22, 1'b0, -1, 1'b0);
        rx_busy = 1'b1;
        repeat (10) step();
        enable_req = 1'b0;
        repeat (3) step();
        check("pre_rst_drain", {active, out_valid, err_count}, {1'b1, 1'b1, 8'd1});
        rst = 1'b1; step();
        check("rst_drain", {rx_en, out_valid, overflow, err_count, out_data}, 0);
        rst = 1'b0; rx_busy = 1'b0;

        rand_mode = 1'b1;
        enable_req = 1'b1;
        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = $urandom_range(0, 12);
            for (int g = 0; g < gap; g++) step();
            if (rx_en) begin
                frame(8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0), -1, 1'b0);
            end else begin
                rx_done = 1'b1; rx_data = 8'($urandom_range(0, 255));
                step();
                rx_done = 1'b0; enable_req = 1'b1;
                step();
            end
        end
        rand_mode = 1'b0;
        clr_status = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        check("rand_drained", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout reached at t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
